control_unit: RTL and testbench

Sequencer for the 8-bit accumulator CPU. It fetches instructions over the program memory interface (`addr_program` out, `data_program` in) and decodes them. It executes them by driving the data memory interface (`cmd_memory`, `addr_memory`, data bus) and an internal accumulator. It is instantiated inside `cpu`, which owns the tri-state `data_memory` pin using `mem_wdata` and `mem_oe`.

---
 rtl/control_unit_if.sv | 35 +++
 rtl/control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Program and data memory bus of the accumulator CPU sequencer.
// The master side belongs to control_unit. The slave side is the memory system:
// the program ROM plus the data memory that sits behind the tri-state pin in cpu.
interface control_unit_if;
  logic [7:0] addr_program;
  logic [7:0] data_program;
  logic [7:0] cmd_memory;
  logic [7:0] addr_memory;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_oe;
  logic       mem_ready;

  modport master (
    output addr_program,
    output cmd_memory,
    output addr_memory,
    output mem_wdata,
    output mem_oe,
    input  data_program,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  addr_program,
    input  cmd_memory,
    input  addr_memory,
    input  mem_wdata,
    input  mem_oe,
    output data_program,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// It fetches from a combinational program ROM and executes against a handshaked
// data memory (mem_ready).
// Optional build macro CU_MEM_TIMEOUT_EN: a memory command still waiting after
// MEM_TIMEOUT cycles is abandoned. The unit then sets err and halts.
// All memory-side outputs are registers. Nothing from an input reaches them combinationally.
module control_unit #(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  control_unit_if.master     bus,
  output logic [7:0]         acc,
  output logic               carry,
  output logic               zero,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_MEM_RD  = 3'd3,
    ST_MEM_WR  = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [3:0] ir_q;       // only the opcode nibble matters; the low nibble is never used
  logic [7:0] opr_q;      // operand of a memory instruction, driven as addr_memory while in MEM states
  logic [7:0] acc_q;
  logic       carry_q;
  logic       halted_q;
  logic       err_q;
  logic [7:0] cmd_q;
  logic [7:0] wdata_q;
  logic       oe_q;

  logic [7:0] pc_inc_d;
  logic [7:0] alu_acc_d;
  logic       alu_carry_d;

`ifdef CU_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] wait_q;
`else
  // The timeout length is kept so that both builds have the same parameter list.
  // Without the timeout feature it only forms this empty block.
  if (MEM_TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Result of the memory-read instructions, applied when mem_ready completes the read.
  always_comb begin
    pc_inc_d    = pc_q + 8'd1;
    alu_acc_d   = acc_q;
    alu_carry_d = carry_q;
    case (ir_q)
      OP_LDA:  alu_acc_d = bus.mem_rdata;
      OP_ADD:  {alu_carry_d, alu_acc_d} = {1'b0, acc_q} + {1'b0, bus.mem_rdata};
      // The 9-bit difference wraps, so bit 8 is set exactly when acc < M[a] (borrow).
      OP_SUB:  {alu_carry_d, alu_acc_d} = {1'b0, acc_q} - {1'b0, bus.mem_rdata};
      default: begin
        alu_acc_d   = acc_q;
        alu_carry_d = carry_q;
      end
    endcase
  end

  // Sequencer FSM. It holds all architectural state and registered memory outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= 4'h0;
      opr_q    <= 8'h00;
      acc_q    <= 8'h00;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cmd_q    <= CMD_IDLE;
      wdata_q  <= 8'h00;
      oe_q     <= 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
      wait_q   <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= bus.data_program[7:4];
          pc_q    <= pc_inc_d;
          state_q <= ST_DECODE;
        end

        ST_DECODE: begin
          case (ir_q)
            OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_LDI, OP_JMP, OP_JZ: state_q <= ST_OPERAND;
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            OP_NOP:  state_q <= ST_FETCH;
            default: state_q <= ST_FETCH;   // 8..E behave as one-byte NOPs
          endcase
        end

        ST_OPERAND: begin
          pc_q <= pc_inc_d;
          case (ir_q)
            OP_LDI: begin
              acc_q   <= bus.data_program;
              state_q <= ST_FETCH;
            end
            OP_JMP: begin
              pc_q    <= bus.data_program;
              state_q <= ST_FETCH;
            end
            OP_JZ: begin
              if (acc_q == 8'h00) begin
                pc_q <= bus.data_program;
              end else begin
                pc_q <= pc_inc_d;
              end
              state_q <= ST_FETCH;
            end
            OP_LDA, OP_ADD, OP_SUB: begin
              opr_q   <= bus.data_program;
              cmd_q   <= CMD_READ;
              state_q <= ST_MEM_RD;
`ifdef CU_MEM_TIMEOUT_EN
              wait_q  <= 8'h00;
`endif
            end
            OP_STA: begin
              opr_q   <= bus.data_program;
              cmd_q   <= CMD_WRITE;
              wdata_q <= acc_q;
              oe_q    <= 1'b1;
              state_q <= ST_MEM_WR;
`ifdef CU_MEM_TIMEOUT_EN
              wait_q  <= 8'h00;
`endif
            end
            default: state_q <= ST_FETCH;
          endcase
        end

        ST_MEM_RD: begin
          if (bus.mem_ready) begin
            acc_q   <= alu_acc_d;
            carry_q <= alu_carry_d;
            cmd_q   <= CMD_IDLE;
            opr_q   <= 8'h00;
            state_q <= ST_FETCH;
          end
`ifdef CU_MEM_TIMEOUT_EN
          else if (wait_q == TIMEOUT_LAST) begin
            err_q    <= 1'b1;
            halted_q <= 1'b1;
            cmd_q    <= CMD_IDLE;
            opr_q    <= 8'h00;
            state_q  <= ST_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`else
          else begin
            state_q <= ST_MEM_RD;
          end
`endif
        end

        ST_MEM_WR: begin
          if (bus.mem_ready) begin
            cmd_q   <= CMD_IDLE;
            opr_q   <= 8'h00;
            wdata_q <= 8'h00;
            oe_q    <= 1'b0;
            state_q <= ST_FETCH;
          end
`ifdef CU_MEM_TIMEOUT_EN
          else if (wait_q == TIMEOUT_LAST) begin
            err_q    <= 1'b1;
            halted_q <= 1'b1;
            cmd_q    <= CMD_IDLE;
            opr_q    <= 8'h00;
            wdata_q  <= 8'h00;
            oe_q     <= 1'b0;
            state_q  <= ST_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`else
          else begin
            state_q <= ST_MEM_WR;
          end
`endif
        end

        ST_HALT: begin
          state_q <= ST_HALT;   // only reset leaves HALT
        end

        default: begin
          cmd_q   <= CMD_IDLE;
          opr_q   <= 8'h00;
          wdata_q <= 8'h00;
          oe_q    <= 1'b0;
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.addr_program = pc_q;
  assign bus.cmd_memory   = cmd_q;
  assign bus.addr_memory  = opr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_oe       = oe_q;
  assign acc              = acc_q;
  assign carry            = carry_q;
  assign zero             = (acc_q == 8'h00);
  assign halted           = halted_q;
  assign err              = err_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. It runs an instruction-level reference model ahead of each program.
// The model's expected memory transactions and halt state go into a scoreboard queue.
// A monitor process compares them against what the DUT presents.
module tb_control_unit;
  logic       clk;
  logic       rst_n;
  logic [7:0] acc;
  logic       carry, zero, halted, err;

  control_unit_if bus();

  logic [7:0] rom  [0:255];
  logic [7:0] menv [0:255];   // memory seen by the DUT
  logic [7:0] mmod [0:255];   // memory as the reference model evolves it
  int         dly  [0:1023];  // ready delay for each memory transaction, in order
  int         ridx;

  typedef struct {
    int         kind;   // 0 = completed memory command, 1 = halt
    int         cyc;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] acc;
    logic       carry;
    logic [7:0] pc;
  } ev_t;

  ev_t sbq[$];
  int  n_chk, n_fail, cyc;
  bit  sb_en, halt_seen, run_done;

  assign bus.data_program = rom[bus.addr_program];

  control_unit #(.PC_RESET(8'h00), .MEM_TIMEOUT(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.master),
    .acc    (acc),
    .carry  (carry),
    .zero   (zero),
    .halted (halted),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) cyc = 0;
      else cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data memory: applies each command's ready delay, then serves reads and applies writes.
  initial begin
    bit busy;
    int cnt, cur;
    busy = 0; cnt = 0; cur = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.cmd_memory != 8'h00) begin
        if (!busy) begin
          busy = 1; cnt = 0; cur = dly[ridx]; ridx++;
        end
        if (cnt == cur) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = menv[bus.addr_memory];
          if (bus.cmd_memory == 8'h02) menv[bus.addr_memory] = bus.mem_wdata;
          busy = 0;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 8'($urandom);
          cnt++;
        end
      end else begin
        busy = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));   // must be ignored outside memory states
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard when a command completes or the core halts.
  initial begin
    ev_t e, pe;
    bit  pend;
    pend = 0;
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        pend = 0;
        chk("acc_after_mem", 32'(acc), 32'(pe.acc));
        chk("carry_after_mem", 32'(carry), 32'(pe.carry));
        chk("zero_after_mem", 32'(zero), 32'(pe.acc == 8'h00));
      end
      if (sb_en && rst_n) begin
        if (bus.cmd_memory != 8'h00 && bus.mem_ready) begin
          if (sbq.size() == 0 || sbq[0].kind != 0) begin
            chk("unexpected_mem_cmd", 32'(bus.cmd_memory), 32'h0);
          end else begin
            e = sbq.pop_front();
            chk("mem_cycle", 32'(cyc), 32'(e.cyc));
            chk("mem_cmd", 32'(bus.cmd_memory), 32'(e.cmd));
            chk("mem_addr", 32'(bus.addr_memory), 32'(e.addr));
            chk("mem_oe", 32'(bus.mem_oe), 32'(e.cmd == 8'h02));
            if (e.cmd == 8'h02) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            else chk("mem_wdata_rd", 32'(bus.mem_wdata), 32'h0);
            pe = e;
            pend = 1;
          end
        end
        if (halted && !halt_seen) begin
          halt_seen = 1;
          if (sbq.size() == 0 || sbq[0].kind != 1) begin
            chk("unexpected_halt", 32'(halted), 32'h0);
          end else begin
            e = sbq.pop_front();
            chk("halt_cycle", 32'(cyc), 32'(e.cyc));
            chk("halt_pc", 32'(bus.addr_program), 32'(e.pc));
            chk("halt_acc", 32'(acc), 32'(e.acc));
            chk("halt_carry", 32'(carry), 32'(e.carry));
            chk("halt_cmd", 32'(bus.cmd_memory), 32'h0);
            run_done = 1;
          end
        end
      end
    end
  end

  // Instruction-level reference: executes the ROM and stamps each event with its cycle.
  task automatic model();
    logic [7:0] pc, a, ac;
    logic [3:0] op;
    logic       cy;
    int         t, k, v, s, d;
    ev_t        e;
    pc = 8'h00; ac = 8'h00; cy = 1'b0; t = 0; k = 0;
    for (int step = 0; step < 1000; step++) begin
      op = rom[pc][7:4];
      pc = pc + 8'd1;
      if (op == 4'hF) begin
        e = '{kind: 1, cyc: t + 2, cmd: 8'h00, addr: 8'h00, wdata: 8'h00, acc: ac, carry: cy, pc: pc};
        sbq.push_back(e);
        return;
      end else if (op == 4'h0 || op >= 4'h8) begin
        t += 2;
      end else begin
        a  = rom[pc];
        pc = pc + 8'd1;
        if (op == 4'h5) begin
          ac = a; t += 3;
        end else if (op == 4'h6) begin
          pc = a; t += 3;
        end else if (op == 4'h7) begin
          if (ac == 8'h00) pc = a;
          t += 3;
        end else begin
          d = dly[k]; k++;
          v = int'(mmod[a]);
          if (op == 4'h1) ac = 8'(v);
          if (op == 4'h3) begin s = int'(ac) + v; cy = (s > 255); ac = 8'(s % 256); end
          if (op == 4'h4) begin cy = (int'(ac) < v); ac = 8'((int'(ac) - v + 256) % 256); end
          if (op == 4'h2) mmod[a] = ac;
          e = '{kind: 0, cyc: t + 3 + d, cmd: (op == 4'h2) ? 8'h02 : 8'h01, addr: a,
                wdata: ac, acc: ac, carry: cy, pc: pc};
          sbq.push_back(e);
          t += 4 + d;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_addr_program", 32'(bus.addr_program), 32'h00);
    chk("rst_cmd", 32'(bus.cmd_memory), 32'h00);
    chk("rst_addr_memory", 32'(bus.addr_memory), 32'h00);
    chk("rst_wdata_oe", 32'({bus.mem_wdata, bus.mem_oe}), 32'h0);
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_flags", 32'({carry, zero, halted, err}), 32'b0100);
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic rand_env();
    for (int i = 0; i < 256; i++) menv[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) dly[i] = $urandom_range(0, 3);
  endtask

  task automatic run_prog(input string tag);
    int bad;
    sb_en = 0;
    sbq.delete();
    for (int i = 0; i < 256; i++) mmod[i] = menv[i];
    ridx = 0;
    model();
    do_reset();
    halt_seen = 0;
    run_done  = 0;
    sb_en     = 1;
    for (int c = 0; c < 3000 && !run_done; c++) @(negedge clk);
    chk({"run_done_", tag}, 32'(run_done), 32'h1);
    repeat (2) @(negedge clk);
    sb_en = 0;
    chk({"sb_empty_", tag}, 32'(sbq.size()), 32'h0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (menv[i] !== mmod[i]) bad++;
    chk({"mem_image_", tag}, 32'(bad), 32'h0);
  endtask

  task automatic gen_prog();
    int n, pos, j;
    int ia [0:31];
    logic [3:0] ops [0:31];
    logic [3:0] pick [0:9];
    logic [7:0] b;
    pick = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'h5};
    fill_rom();
    n = $urandom_range(8, 20);
    pos = 0;
    for (int i = 0; i < n; i++) begin
      ops[i] = pick[$urandom_range(0, 9)];
      ia[i]  = pos;
      pos   += (ops[i] >= 4'h1 && ops[i] <= 4'h7) ? 2 : 1;
    end
    ia[n] = pos;   // HLT at the end; the rest of the ROM is HLT too
    for (int i = 0; i < n; i++) begin
      rom[ia[i]] = {ops[i], 4'($urandom)};
      if (ops[i] >= 4'h1 && ops[i] <= 4'h4) begin
        rom[ia[i] + 1] = 8'h80 + 8'($urandom_range(0, 7));
      end else if (ops[i] == 4'h5) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rom[ia[i] + 1] = b;
      end else if (ops[i] == 4'h6 || ops[i] == 4'h7) begin
        j = $urandom_range(n, i + 1);
        rom[ia[i] + 1] = 8'(ia[j]);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; sb_en = 0; ridx = 0;
    rst_n = 1'b0;
    fill_rom();
    rand_env();

    // LDI then STA, with ready immediately; then the core stays halted
    fill_rom();
    rom[0] = 8'h50; rom[1] = 8'h5A; rom[2] = 8'h20; rom[3] = 8'h10;
    for (int i = 0; i < 8; i++) dly[i] = 0;
    run_prog("ldi_sta");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("halt_hold", 32'({bus.addr_program, bus.cmd_memory, halted}), 32'({8'h05, 8'h00, 1'b1}));
    end

    // LDA with 3 wait cycles, then ADD (carry out), then SUB (borrow)
    fill_rom();
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h30; rom[3] = 8'h20;
    rom[4] = 8'h40; rom[5] = 8'h20;
    menv[8'h20] = 8'hF0;
    dly[0] = 3; dly[1] = 0; dly[2] = 0;
    run_prog("lda_add_sub");

    // JZ taken and not taken
    fill_rom();
    rom[0] = 8'h50; rom[1] = 8'h00; rom[2] = 8'h70; rom[3] = 8'h40;
    run_prog("jz_taken");
    rom[1] = 8'h01;
    run_prog("jz_fall");

    // PC wrap, including an operand fetched from address 00
    fill_rom();
    rom[8'h00] = 8'h60; rom[8'h01] = 8'hFC;
    rom[8'hFC] = 8'h50; rom[8'hFD] = 8'h11; rom[8'hFE] = 8'h05; rom[8'hFF] = 8'h50;
    run_prog("pc_wrap");

    // Reset while a read is outstanding drops the command
    fill_rom();
    rom[0] = 8'h10; rom[1] = 8'h20;
    dly[0] = 500;
    sb_en = 0; ridx = 0;
    do_reset();
    repeat (8) @(negedge clk);
    #1;
    chk("mid_cmd_before", 32'(bus.cmd_memory), 32'h01);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_cmd_after", 32'({bus.cmd_memory, bus.mem_oe}), 32'h0);
    rst_n = 1'b1;

    // Memory never ready
    fill_rom();
    rom[0] = 8'h50; rom[1] = 8'hA5; rom[2] = 8'h10; rom[3] = 8'h33;
    dly[0] = 100000;
    ridx = 0;
    do_reset();
`ifdef CU_MEM_TIMEOUT_EN
    for (int c = 0; c < 60 && !halted; c++) @(negedge clk);
    chk("to_cycle", 32'(cyc), 32'd22);
    #1;
    chk("to_flags", 32'({err, halted}), 32'b11);
    chk("to_acc", 32'(acc), 32'hA5);
    chk("to_cmd", 32'(bus.cmd_memory), 32'h00);
`else
    repeat (40) @(negedge clk);
    #1;
    chk("wait_cmd", 32'(bus.cmd_memory), 32'h01);
    chk("wait_addr", 32'(bus.addr_memory), 32'h33);
    chk("wait_flags", 32'({err, halted}), 32'b00);
    chk("wait_acc", 32'(acc), 32'hA5);
`endif

    // Randomized programs
    for (int r = 0; r < 30; r++) begin
      rand_env();
      gen_prog();
      run_prog("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
